// File: rtl/div_unit_if.sv
// Start/done/div_0 handshake and operand/result bus between the control unit and the divider.
// The master (control unit) drives start and operands; the slave (divider) returns HI/LO and status.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             div_0;

    modport master (
        output start, A, B,
        input  HI, LO, busy, done, div_0
    );

    modport slave (
        input  start, A, B,
        output HI, LO, busy, done, div_0
    );
endinterface

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient to LO, remainder to HI, 33 cycles from accept to done.
// start is only sampled in IDLE; divide-by-zero answers with a one-cycle done+div_0 and leaves HI/LO alone.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic       clk,
    input logic       reset,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     rem;
    logic [WIDTH:0]     dvs;
    logic [WIDTH-1:0]   quo;
    logic               sign_q;
    logic               sign_r;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               div0_q;

    // The dividend magnitude is read as unsigned, so |-2^31| = 0x80000000 stays exact in WIDTH bits.
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH:0]     b_mag;
    logic [WIDTH+1:0]   rem_sh;
    logic [WIDTH:0]     rem_sub;
    logic               ge;

    always_comb begin
        a_mag   = bus.A[WIDTH-1] ? -bus.A : bus.A;
        b_ext   = {bus.B[WIDTH-1], bus.B};
        b_mag   = b_ext[WIDTH] ? -b_ext : b_ext;
        rem_sh  = {rem, quo[WIDTH-1]};
        ge      = (rem_sh >= {1'b0, dvs});
        rem_sub = rem_sh[WIDTH:0] - dvs;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            dvs    <= '0;
            quo    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            div0_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.B == '0) begin
                            done_q <= 1'b1;
                            div0_q <= 1'b1;
                        end else begin
                            quo    <= a_mag;
                            dvs    <= b_mag;
                            rem    <= '0;
                            cnt    <= '0;
                            sign_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                            sign_r <= bus.A[WIDTH-1];
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem <= ge ? rem_sub : rem_sh[WIDTH:0];
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo_q   <= sign_q ? -quo : quo;
                    hi_q   <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.div_0 = div0_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: stimulus pushes hand-computed results into a queue,
// an independent monitor pops and compares on every done pulse.
module tb_div_unit;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(32)) bus();

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin : monitor
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.div_0 && !bus.done) begin
                checks++;
                errors++;
                $display("FAIL div0_without_done at cycle %0d", cyc);
            end
            if (bus.done) begin
                chk("done_one_cycle", 32'(prev_done), 32'd0);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: LO=%h HI=%h at cycle %0d", bus.LO, bus.HI, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_LO"},    bus.LO, e.lo);
                    chk({e.name, "_HI"},    bus.HI, e.hi);
                    chk({e.name, "_div0"},  32'(bus.div_0), 32'(e.dz));
                    chk({e.name, "_cycle"}, cyc, e.cyc);
                    chk({e.name, "_busy"},  32'(bus.busy), 32'd0);
                end
            end
            prev_done = bus.done;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi,
                         input logic dz, input string nm);
        exp_t e;
        e.lo   = lo;
        e.hi   = hi;
        e.dz   = dz;
        e.cyc  = cyc + (dz ? 1 : 34);
        e.name = nm;
        sbq.push_back(e);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        if (!dz) chk({nm, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done still 0 after %0d cycles", nm, n);
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lo, input logic [31:0] hi,
                       input logic dz, input string nm);
        issue(a, b, lo, hi, dz, nm);
        wait_done(nm);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        chk("rst_HI",   bus.HI, 32'd0);
        chk("rst_LO",   bus.LO, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_div0", 32'(bus.div_0), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_LO",   bus.LO, 32'd0);

        run(32'd100,        32'd7,          32'd14,         32'd2,          1'b0, "pos_pos");
        run(32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, "neg_pos");
        run(32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, "pos_neg");
        run(32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, "neg_neg");
        run(32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, "min_by_m1");
        run(32'd5,          32'd9,          32'd0,          32'd5,          1'b0, "small_div");
        run(32'd100,        32'd7,          32'd14,         32'd2,          1'b0, "prep");
        run(32'd42,         32'd0,          32'd14,         32'd2,          1'b1, "div_zero");

        // Operands and start changing mid-run must not disturb the division.
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "ignore_restart");
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 32'd1234;
        bus.B     = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 32'hDEADBEEF;
        bus.B     = 32'd0;
        wait_done("ignore_restart");
        issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, "back_to_back");
        wait_done("back_to_back");
        @(negedge clk);

        // Reset mid-operation: everything clears and no done follows.
        bus.start = 1'b1;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_HI",   bus.HI, 32'd0);
        chk("midrst_LO",   bus.LO, 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (45) @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_LO",   bus.LO, 32'd0);
        chk("queue_empty",   sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
